// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and open-drain PS/2 line signals for the host transmitter
interface ps2_host_tx_if;
   logic       Start;
   logic [7:0] TxData;
   logic       ClkKB;
   logic       DataKB;
   logic       ClkKBDriveLow;
   logic       DataKBDriveLow;
   logic       Busy;
   logic       Done;
   logic       Error;

   modport master (
      output Start, TxData, ClkKB, DataKB,
      input  ClkKBDriveLow, DataKBDriveLow, Busy, Done, Error
   );

   modport slave (
      input  Start, TxData, ClkKB, DataKB,
      output ClkKBDriveLow, DataKBDriveLow, Busy, Done, Error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (request-to-send, 8 data bits LSB first, odd parity, stop, ACK check)
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 250,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic          Clock,
   input logic          Reset,
   ps2_host_tx_if.slave bus
);
   localparam int MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
      ? ((TIMEOUT_CYCLES > REQ_CYCLES) ? TIMEOUT_CYCLES : REQ_CYCLES)
      : ((INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES);
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL, DONE, ERR} stateT;

   stateT            state;
   logic             clkSync1, clkSync2, clkPrev;
   logic             dataSync1, dataSync2;
   logic [8:0]       shreg;
   logic [3:0]       bitCnt;
   logic [CNT_W-1:0] cnt;
   logic             fall, inFrame, released, nack, expired;

   assign fall     = clkPrev & ~clkSync2;
   assign inFrame  = state inside {SEND, ACK, WAIT_REL};
   assign released = clkSync2 & dataSync2;
   assign nack     = (state == ACK) && fall && dataSync2;
   assign expired  = inFrame && !fall && (cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                     && !((state == WAIT_REL) && released);

   // Two-flop synchronizers on the raw lines; idle-high reset avoids a false fall after reset
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         clkSync1  <= 1'b1;
         clkSync2  <= 1'b1;
         clkPrev   <= 1'b1;
         dataSync1 <= 1'b1;
         dataSync2 <= 1'b1;
      end else begin
         clkSync1  <= bus.ClkKB;
         clkSync2  <= clkSync1;
         clkPrev   <= clkSync2;
         dataSync1 <= bus.DataKB;
         dataSync2 <= dataSync1;
      end

   // Frame sequencer; all outputs are registered and set on the transition into each state
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state              <= IDLE;
         shreg              <= '0;
         bitCnt             <= '0;
         cnt                <= '0;
         bus.Busy           <= 1'b0;
         bus.Done           <= 1'b0;
         bus.Error          <= 1'b0;
         bus.ClkKBDriveLow  <= 1'b0;
         bus.DataKBDriveLow <= 1'b0;
      end else begin
         bus.Done  <= 1'b0;
         bus.Error <= 1'b0;
         if (inFrame) cnt <= fall ? '0 : cnt + 1'b1;
         if (nack || expired) begin
            state              <= ERR;
            bus.Error          <= 1'b1;
            bus.Busy           <= 1'b0;
            bus.ClkKBDriveLow  <= 1'b0;
            bus.DataKBDriveLow <= 1'b0;
         end else
            case (state)
               IDLE:
                  if (bus.Start) begin
                     shreg             <= {~^bus.TxData, bus.TxData};
                     bitCnt            <= '0;
                     cnt               <= '0;
                     bus.Busy          <= 1'b1;
                     bus.ClkKBDriveLow <= 1'b1;
                     state             <= INHIBIT;
                  end
               INHIBIT:
                  if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                     cnt                <= '0;
                     bus.DataKBDriveLow <= 1'b1;
                     state              <= REQ;
                  end else
                     cnt <= cnt + 1'b1;
               REQ:
                  if (cnt == CNT_W'(REQ_CYCLES - 1)) begin
                     cnt               <= '0;
                     bus.ClkKBDriveLow <= 1'b0;
                     state             <= SEND;
                  end else
                     cnt <= cnt + 1'b1;
               SEND:
                  if (fall) begin
                     bitCnt             <= bitCnt + 1'b1;
                     bus.DataKBDriveLow <= (bitCnt == 4'd9) ? 1'b0 : ~shreg[bitCnt];
                     if (bitCnt == 4'd9) state <= ACK;
                  end
               ACK:
                  if (fall) state <= WAIT_REL;
               WAIT_REL:
                  if (released) begin
                     state    <= DONE;
                     bus.Done <= 1'b1;
                     bus.Busy <= 1'b0;
                  end
               default:
                  state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed frames against a PS/2 device model with bit and outcome scoreboards
module tb_ps2_host_tx;
   localparam int INH = 200;
   localparam int REQ = 20;
   localparam int TO  = 300;
   localparam int H   = 20;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       devClkLow = 1'b0;
   logic       devDataLow = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         doneCnt = 0;
   logic       expBits[$];
   bit         expOk[$];
   logic [4:0] seen[$];

   ps2_host_tx_if bus();

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus(bus)
   );

   always #5 Clock = ~Clock;

   // Open-drain wired-AND of host and device pull-downs
   assign bus.ClkKB  = ~(bus.ClkKBDriveLow | devClkLow);
   assign bus.DataKB = ~(bus.DataKBDriveLow | devDataLow);

   // Record every Done/Error cycle with the other outputs seen alongside it
   always @(negedge Clock)
      if (bus.Done || bus.Error) begin
         seen.push_back({bus.Done, bus.Error, bus.Busy, bus.ClkKBDriveLow, bus.DataKBDriveLow});
         if (bus.Done) doneCnt++;
      end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sendByte(input logic [7:0] d, input bit ok, input bit withBits);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      if (withBits) begin
         for (int i = 0; i < 8; i++) expBits.push_back(d[i]);
         expBits.push_back(ones % 2 == 0);
         expBits.push_back(1'b1);
      end
      expOk.push_back(ok);
      bus.TxData = d;
      bus.Start  = 1'b1;
      @(negedge Clock);
      bus.Start  = 1'b0;
      check("busy latency", bus.Busy, 1);
      check("clk low latency", bus.ClkKBDriveLow, 1);
   endtask

   task automatic phases(output int inh, output int req);
      inh = 0;
      req = 0;
      while (bus.ClkKBDriveLow && !bus.DataKBDriveLow && inh < 4 * INH) begin
         @(negedge Clock);
         inh++;
      end
      while (bus.ClkKBDriveLow && bus.DataKBDriveLow && req < 4 * REQ) begin
         @(negedge Clock);
         req++;
      end
   endtask

   task automatic device(input bit ack, input int stopAfter, output logic [9:0] got);
      got = '0;
      check("start bit", bus.DataKB, 0);
      check("clk released", bus.ClkKB, 1);
      repeat (H) @(negedge Clock);
      for (int k = 1; k <= 11; k++) begin
         devClkLow = 1'b1;
         repeat (H) @(negedge Clock);
         if (k == stopAfter) return;
         if (k <= 10) begin
            got[k-1] = bus.DataKB;
            if (expBits.size() > 0) check($sformatf("bit%0d", k), bus.DataKB, expBits.pop_front());
            else begin
               checks++;
               errors++;
               $error("FAIL bitq%0d: observed empty queue expected a bit", k);
            end
         end
         devClkLow = 1'b0;
         repeat (H / 2) @(negedge Clock);
         if (k == 10) devDataLow = ack;
         repeat (H / 2) @(negedge Clock);
      end
      devDataLow = 1'b0;
   endtask

   task automatic waitEnd(input string tag);
      logic [4:0] ev;
      bit         ok;
      int         n = 0;
      while (seen.size() == 0 && n < 4 * TO) begin
         @(negedge Clock);
         n++;
      end
      ev = (seen.size() > 0) ? seen.pop_front() : 5'b0;
      ok = expOk.pop_front();
      check({tag, " done"}, ev[4], ok);
      check({tag, " error"}, ev[3], !ok);
      check({tag, " busy"}, ev[2], 0);
      check({tag, " lines"}, ev[1:0], 0);
      @(negedge Clock);
      check({tag, " pulse"}, bus.Done | bus.Error, 0);
   endtask

   initial begin
      logic [9:0] got;
      int inh, req, n, d0;
      bus.Start  = 1'b0;
      bus.TxData = 8'h00;
      repeat (3) @(negedge Clock);
      check("reset outputs",
            {bus.Busy, bus.Done, bus.Error, bus.ClkKBDriveLow, bus.DataKBDriveLow}, 0);
      Reset = 1'b1;
      repeat (3) @(negedge Clock);

      // 1: 0xED full frame with ACK
      sendByte(8'hED, 1, 1);
      phases(inh, req);
      check("inhibit cycles", inh, INH);
      check("req cycles", req, REQ);
      device(1, 0, got);
      check("ED bits", got, 10'b11_1110_1101);
      waitEnd("ED");

      // 2: parity corners
      sendByte(8'h01, 1, 1);
      phases(inh, req);
      device(1, 0, got);
      check("parity 01", got[8], 0);
      waitEnd("01");
      sendByte(8'hFF, 1, 1);
      phases(inh, req);
      device(1, 0, got);
      check("parity FF", got[8], 1);
      waitEnd("FF");

      // 3: device withholds ACK
      sendByte(8'h3C, 0, 1);
      phases(inh, req);
      device(0, 0, got);
      waitEnd("nack");
      check("nack clk line", bus.ClkKB, 1);
      check("nack data line", bus.DataKB, 1);

      // 4: device never clocks
      sendByte(8'h22, 0, 0);
      phases(inh, req);
      n = 0;
      while (!bus.Error && n < TO + 50) begin
         @(negedge Clock);
         n++;
      end
      check("timeout window", (n >= TO) && (n <= TO + 3), 1);
      waitEnd("timeout");

      // 5: second Start and TxData change mid-frame are ignored
      d0 = doneCnt;
      sendByte(8'h55, 1, 1);
      bus.TxData = 8'hAA;
      bus.Start  = 1'b1;
      @(negedge Clock);
      bus.Start  = 1'b0;
      bus.TxData = 8'h0F;
      phases(inh, req);
      device(1, 0, got);
      check("55 data", got[7:0], 8'h55);
      waitEnd("55");
      repeat (INH + REQ + 10) @(negedge Clock);
      check("55 no refire", bus.Busy, 0);
      check("55 one done", doneCnt - d0, 1);

      // 6: async reset after fall 4, then a clean frame
      sendByte(8'hA3, 1, 1);
      phases(inh, req);
      device(1, 4, got);
      Reset = 1'b0;
      #1;
      check("reset mid busy", bus.Busy, 0);
      check("reset mid lines", {bus.ClkKBDriveLow, bus.DataKBDriveLow}, 0);
      devClkLow  = 1'b0;
      devDataLow = 1'b0;
      expBits.delete();
      expOk.delete();
      seen.delete();
      repeat (5) @(negedge Clock);
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      sendByte(8'hF4, 1, 1);
      phases(inh, req);
      check("F4 inhibit", inh, INH);
      check("F4 req", req, REQ);
      device(1, 0, got);
      check("F4 data", got[7:0], 8'hF4);
      waitEnd("F4");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
